// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared constants and types for the multiply/divide unit.
// Holds op encodings, the FSM state enum, the default operand width, the
// number of CALC iterations and a small signedness helper.
// The optional divide datapath is selected by the MULDIV_DIV_EN macro.
package muldiv_pkg;
    localparam int DEF_WIDTH = 32;
    localparam int CALC_ITERS = DEF_WIDTH;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PREP = 2'd1,
        S_CALC = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    // op[0]=0 marks the signed variants (MULT, DIV)
    function automatic logic op_signed(input logic [1:0] op);
        return ~op[0];
    endfunction
endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: handshake and data bundle between the control unit and muldiv_unit.
// Ports: start, op, rs_val, rt_val, mthi, mtlo (control -> unit);
//        busy, done, hi, lo (unit -> control).
// Modports: master (control unit side), slave (muldiv_unit side).
interface muldiv_if #(parameter int WIDTH = muldiv_pkg::DEF_WIDTH);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic             mthi;
    logic             mtlo;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, rs_val, rt_val, mthi, mtlo,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, rs_val, rt_val, mthi, mtlo,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_signfix.sv
// muldiv_signfix: combinational two's-complement negation shared by PREP and FIX.
// Ports: hi_in/lo_in (two WIDTH-bit lanes), neg_hi/neg_lo (negate each lane),
//        wide (treat {hi_in,lo_in} as one 2*WIDTH value; caller sets neg_hi=neg_lo),
//        hi_out/lo_out (results).
// PREP uses it for operand magnitudes, FIX for product/quotient/remainder signs.
module muldiv_signfix import muldiv_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] hi_in,
    input  logic [WIDTH-1:0] lo_in,
    input  logic             neg_hi,
    input  logic             neg_lo,
    input  logic             wide,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);
    // Low half of a wide negation equals the negation of the low lane alone;
    // the high half only receives the +1 carry when the low lane is zero.
    assign lo_out = neg_lo ? -lo_in : lo_in;
    assign hi_out = neg_hi ? ~hi_in + WIDTH'(wide ? (lo_in == '0) : 1'b1) : hi_in;
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MIPS multiply/divide unit owning the HI/LO registers.
// Ports: clk, reset (async, active-high), bus (muldiv_if.slave:
//        start/op/rs_val/rt_val/mthi/mtlo in, busy/done/hi/lo out).
// Sequence: IDLE -> PREP -> CALC (WIDTH cycles) -> FIX -> IDLE; done pulses
// for the cycle after FIX. Define MULDIV_DIV_EN to include DIV/DIVU; without
// it, starts with op[1]=1 are ignored.
module muldiv_unit import muldiv_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH
) (
    input logic      clk,
    input logic      reset,
    muldiv_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    state_t             state, state_nx;
    logic               sgn_r, sdiff, done_r, is_div, accept;
    logic               wide, neg_hi, neg_lo, fix_neg_hi;
    logic [2*WIDTH-1:0] acc, step;
    logic [WIDTH-1:0]   opnd, hi_r, lo_r, fx_hi, fx_lo;
    logic [WIDTH:0]     msum;
    logic [CW-1:0]      cnt;

`ifdef MULDIV_DIV_EN
    logic               div_r, rs_neg, dok;
    logic [WIDTH:0]     dsh;
    logic [WIDTH-1:0]   drem;
    assign is_div     = div_r;
    assign accept     = bus.start;
    assign fix_neg_hi = div_r ? rs_neg : sdiff;
`else
    assign is_div     = 1'b0;
    assign accept     = bus.start & ~bus.op[1];
    assign fix_neg_hi = sdiff;
`endif

    assign bus.busy = state != S_IDLE;
    assign bus.done = done_r;
    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;

    // acc holds {rs,rt} in PREP, {product} for multiply, {remainder,quotient} for divide
    assign wide   = state == S_FIX && !is_div;
    assign neg_hi = state == S_FIX ? fix_neg_hi : sgn_r & acc[2*WIDTH-1];
    assign neg_lo = state == S_FIX ? sdiff : sgn_r & acc[WIDTH-1];

    muldiv_signfix #(.WIDTH(WIDTH)) u_signfix (
        .hi_in  (acc[2*WIDTH-1:WIDTH]),
        .lo_in  (acc[WIDTH-1:0]),
        .neg_hi (neg_hi),
        .neg_lo (neg_lo),
        .wide   (wide),
        .hi_out (fx_hi),
        .lo_out (fx_lo)
    );

    // One CALC iteration: shift-add (multiplier in acc low half) or restoring divide
    always_comb begin
        msum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : {WIDTH{1'b0}})};
        step = {msum, acc[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
        dsh  = acc[2*WIDTH-1:WIDTH-1];
        dok  = dsh >= {1'b0, opnd};
        drem = dsh[WIDTH-1:0] - (dok ? opnd : {WIDTH{1'b0}});
        step = div_r ? {drem, acc[WIDTH-2:0], dok} : step;
`endif
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: state_nx = accept ? S_PREP : S_IDLE;
            S_PREP: state_nx = S_CALC;
            S_CALC: state_nx = cnt == CW'(WIDTH - 1) ? S_FIX : S_CALC;
            S_FIX:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else state <= state_nx;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc    <= '0;
            opnd   <= '0;
            cnt    <= '0;
            sgn_r  <= 1'b0;
            sdiff  <= 1'b0;
            done_r <= 1'b0;
            hi_r   <= '0;
            lo_r   <= '0;
`ifdef MULDIV_DIV_EN
            div_r  <= 1'b0;
            rs_neg <= 1'b0;
`endif
        end else begin
            done_r <= state == S_FIX;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        acc   <= {bus.rs_val, bus.rt_val};
                        sgn_r <= op_signed(bus.op);
`ifdef MULDIV_DIV_EN
                        div_r <= bus.op[1];
`endif
                    end else begin
                        if (bus.mthi) hi_r <= bus.rs_val;
                        if (bus.mtlo) lo_r <= bus.rs_val;
                    end
                end
                S_PREP: begin
                    // multiply: opnd=|rs|, acc low=|rt|; divide: opnd=|rt|, acc low=|rs|
                    cnt   <= '0;
                    sdiff <= neg_hi ^ neg_lo;
                    opnd  <= is_div ? fx_lo : fx_hi;
                    acc   <= {{WIDTH{1'b0}}, (is_div ? fx_hi : fx_lo)};
`ifdef MULDIV_DIV_EN
                    rs_neg <= neg_hi;
`endif
                end
                S_CALC: begin
                    cnt <= cnt + CW'(1);
                    acc <= step;
                end
                S_FIX: begin
                    hi_r <= fx_hi;
                    lo_r <= fx_lo;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: self-checking bench for muldiv_unit with a 64-bit arithmetic reference model.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic clk, reset;
    int checks = 0;
    int failures = 0;

    muldiv_if #(.WIDTH(32)) bus ();

    muldiv_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: HI/LO as {hi,lo} from plain 64-bit arithmetic
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        logic [63:0] ua = {32'b0, a};
        logic [63:0] ub = {32'b0, b};
        logic [63:0] p;
        logic [31:0] q, r;
        case (o)
            OP_MULT:  begin p = 64'(sa * sb); return p; end
            OP_MULTU: begin p = ua * ub; return p; end
            OP_DIV: begin
                if (b == 0) begin
                    q = a[31] ? 32'h1 : 32'hFFFF_FFFF;
                    r = a;
                end else begin
                    q = 32'(sa / sb);
                    r = 32'(sa % sb);
                end
            end
            default: begin
                if (b == 0) begin
                    q = 32'hFFFF_FFFF;
                    r = a;
                end else begin
                    q = a / b;
                    r = a % b;
                end
            end
        endcase
        return {r, q};
    endfunction

    // Present start for one cycle; caller is at a negedge
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.op = o;
        bus.rs_val = a;
        bus.rt_val = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.rs_val = $urandom;
        bus.rt_val = $urandom;
    endtask

    // Count busy cycles after E0, then check done and HI/LO; returns in the done cycle
    task automatic wait_done(input string tag, input logic [63:0] exp);
        int n = 0;
        while (bus.busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk({tag, " busy_cycles"}, 64'(n), 64'd34);
        chk({tag, " done"}, 64'(bus.done), 64'd1);
        chk({tag, " hilo"}, {bus.hi, bus.lo}, exp);
    endtask

    task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        issue(o, a, b);
        wait_done(tag, model(o, a, b));
    endtask

    initial begin
        logic [1:0] o;
        logic [31:0] a, b;
        int dones;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.op = 2'b00;
        bus.rs_val = '0;
        bus.rt_val = '0;
        bus.mthi = 1'b0;
        bus.mtlo = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("reset busy", 64'(bus.busy), 64'd0);
        chk("reset done", 64'(bus.done), 64'd0);
        chk("reset hilo", {bus.hi, bus.lo}, 64'd0);

        // MTHI / MTLO single-edge writes
        bus.mthi = 1'b1;
        bus.rs_val = 32'h1234;
        @(negedge clk);
        bus.mthi = 1'b0;
        chk("mthi hilo", {bus.hi, bus.lo}, {32'h1234, 32'h0});
        chk("mthi busy", 64'(bus.busy), 64'd0);
        bus.mtlo = 1'b1;
        bus.rs_val = 32'h5678;
        @(negedge clk);
        bus.mtlo = 1'b0;
        chk("mtlo hilo", {bus.hi, bus.lo}, {32'h1234, 32'h5678});
        bus.mthi = 1'b1;
        bus.mtlo = 1'b1;
        bus.rs_val = 32'hA5A5;
        @(negedge clk);
        bus.mthi = 1'b0;
        bus.mtlo = 1'b0;
        chk("mthi+mtlo hilo", {bus.hi, bus.lo}, {32'hA5A5, 32'hA5A5});

        // start/mthi/mtlo during busy are ignored; HI/LO hold until FIX
        issue(OP_MULT, 32'd5, 32'd6);
        repeat (5) @(negedge clk);
        bus.start = 1'b1;
        bus.mthi = 1'b1;
        bus.mtlo = 1'b1;
        bus.op = OP_MULTU;
        bus.rs_val = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.start = 1'b0;
        bus.mthi = 1'b0;
        bus.mtlo = 1'b0;
        chk("busy hold hilo", {bus.hi, bus.lo}, {32'hA5A5, 32'hA5A5});
        begin
            int n = 6;
            while (bus.busy === 1'b1 && n < 100) begin
                n++;
                @(negedge clk);
            end
            chk("busy ignore cycles", 64'(n), 64'd34);
        end
        chk("busy ignore hilo", {bus.hi, bus.lo}, 64'd30);
        @(negedge clk);
        chk("done one cycle", 64'(bus.done), 64'd0);

        // start wins over mthi in the same cycle
        bus.mthi = 1'b1;
        issue(OP_MULTU, 32'h10, 32'h3);
        bus.mthi = 1'b0;
        chk("start+mthi hi held", 64'(bus.hi), 64'd0);
        wait_done("start+mthi", 64'h30);

        // Directed multiplies
        @(negedge clk);
        issue(OP_MULT, 32'd7, 32'hFFFF_FFFD);
        wait_done("mult 7*-3", {32'hFFFF_FFFF, 32'hFFFF_FFEB});
        // back-to-back: next start in the done cycle
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("b2b done drops", 64'(bus.done), 64'd0);
        wait_done("multu max", {32'hFFFF_FFFE, 32'h0000_0001});

        for (int i = 0; i < 16; i++) begin
            o = 2'($urandom_range(0, 1));
            a = $urandom;
            b = (i == 3) ? 32'h8000_0000 : $urandom;
            do_op($sformatf("rand mul %0d", i), o, a, b);
        end

`ifdef MULDIV_DIV_EN
        do_op("div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2);
        chk("div -7/2 const", {bus.hi, bus.lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        do_op("divu 100/7", OP_DIVU, 32'd100, 32'd7);
        chk("divu 100/7 const", {bus.hi, bus.lo}, {32'h2, 32'hE});
        do_op("divu /0", OP_DIVU, 32'h64, 32'h0);
        chk("divu /0 const", {bus.hi, bus.lo}, {32'h64, 32'hFFFF_FFFF});
        do_op("div ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("div ovf const", {bus.hi, bus.lo}, {32'h0, 32'h8000_0000});
        do_op("div -5/0", OP_DIV, 32'hFFFF_FFFB, 32'h0);
        for (int i = 0; i < 16; i++) begin
            o = 2'($urandom_range(2, 3));
            a = $urandom;
            b = (i % 4 == 0) ? 32'h0 : ((i % 4 == 1) ? 32'($urandom_range(1, 300)) : $urandom);
            do_op($sformatf("rand div %0d", i), o, a, b);
        end
`else
        // divide disabled: DIV start must be ignored entirely
        do_op("pre-div mult", OP_MULT, 32'd9, 32'hFFFF_FFFF);
        @(negedge clk);
        issue(OP_DIV, 32'd100, 32'd7);
        chk("nodiv busy", 64'(bus.busy), 64'd0);
        dones = 0;
        repeat (40) begin
            dones += int'(bus.done);
            @(negedge clk);
        end
        chk("nodiv done count", 64'(dones), 64'd0);
        chk("nodiv hilo", {bus.hi, bus.lo}, {32'hFFFF_FFFF, 32'hFFFF_FFF7});
`endif

        // Reset 10 cycles into a MULT aborts immediately
        @(negedge clk);
        issue(OP_MULT, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort busy", 64'(bus.busy), 64'd0);
        chk("abort hilo", {bus.hi, bus.lo}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        dones = 0;
        repeat (40) begin
            dones += int'(bus.done);
            @(negedge clk);
        end
        chk("abort no done", 64'(dones), 64'd0);
        do_op("after abort", OP_MULT, 32'hFFFF_FF00, 32'd1000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit holding the architectural HI/LO registers of the MIPS core. It sits directly downstream of the register file: it consumes the two read-port values (rs, rt) for MULT/MULTU/DIV/DIVU/MTHI/MTLO and produces HI/LO for MFHI/MFLO writeback. Operations are multi-cycle with a start/busy/done handshake so the control unit can stall.

## Interface
- WIDTH, 32, operand and HI/LO width
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  begin operation selected by op; sampled only in IDLE
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- rs_val  in  WIDTH  register-file port-1 content (multiplicand / dividend / MTHI/MTLO data)
- rt_val  in  WIDTH  register-file port-2 content (multiplier / divisor)
- mthi  in  1  write rs_val to HI
- mtlo  in  1  write rs_val to LO
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

## Operation
- Reset values: busy=0, done=0, hi=0, lo=0, state=IDLE.
- FSM: IDLE -> PREP (1 cycle) -> CALC (WIDTH cycles) -> FIX (1 cycle) -> IDLE.
- IDLE: start=1 latches op, rs_val, rt_val; go PREP. start=0 with mthi/mtlo: write HI/LO from rs_val at that edge; mthi and mtlo together write both.
- start and mthi/mtlo in the same cycle: start wins, mthi/mtlo ignored.
- PREP: form magnitudes (signed ops: two's-complement abs; unsigned: raw); record result signs.
- CALC, multiply: shift-add, one multiplier bit per cycle, 2*WIDTH accumulator.
- CALC, divide: restoring, one quotient bit per cycle; WIDTH-bit remainder plus carry bit.
- FIX: signed multiply negates 64-bit product if operand signs differ; signed divide negates quotient if signs differ, remainder takes dividend sign. HI = product[63:32] / remainder; LO = product[31:0] / quotient.
- Divide by zero (no special path): unsigned gives LO=FFFFFFFF, HI=dividend; signed applies the FIX sign rules to the same magnitudes.
- 0x80000000 / -1 signed: LO=0x80000000, HI=0.
- start, mthi, mtlo while busy: ignored; HI/LO hold previous values until FIX.

## Timing
- start sampled at edge E0; busy=1 for the cycles after E0 through E(WIDTH+2).
- HI/LO written at edge E(WIDTH+2) (E34 for WIDTH=32); busy falls and done=1 for exactly the following cycle.
- Fixed latency, independent of op and operand values.
- Next start may be presented in the done cycle (state is IDLE); back-to-back throughput is one op per WIDTH+3 cycles.
- MTHI/MTLO: single-edge write, visible on hi/lo next cycle; busy is not asserted.
- Reset mid-operation: immediate abort to IDLE, HI/LO=0, no done pulse.

## Configuration
- MULDIV_DIV_EN defined: full behaviour above.
- MULDIV_DIV_EN undefined: divide datapath removed; start with op[1]=1 is ignored (busy stays 0, no done, HI/LO unchanged); MULT/MULTU/MTHI/MTLO unaffected.

## Structure
- Package muldiv_pkg: op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU), FSM state enum, default WIDTH, CALC iteration count constant.
- One sub-module: muldiv_signfix (combinational magnitude extraction in PREP and conditional negation in FIX), instantiated once, shared by multiply and divide.
- FSM, counter, accumulator/remainder and HI/LO registers live in muldiv_unit.

## Test plan
- MULT rs=7, rt=0xFFFFFFFD (-3) -> busy 34 cycles, done pulse, HI=FFFFFFFF, LO=FFFFFFEB; MULTU 0xFFFFFFFF×0xFFFFFFFF -> HI=FFFFFFFE, LO=00000001.
- DIV rs=-7 (FFFFFFF9), rt=2 -> LO=FFFFFFFD, HI=FFFFFFFF; DIVU 100/7 -> LO=0x0E, HI=0x02.
- DIVU 0x64/0 -> LO=FFFFFFFF, HI=0x64; DIV 0x80000000/0xFFFFFFFF -> LO=80000000, HI=0.
- MTHI rs=0x1234 in IDLE -> hi=0x1234 next cycle; MTLO and start during busy -> ignored, result of running op written at E34; start+mthi same cycle -> only op runs.
- Reset asserted 10 cycles into MULT -> busy=0, hi=lo=0 immediately, no done; new MULT afterwards completes normally.
- MULDIV_DIV_EN undefined: DIV start -> busy stays 0, no done, HI/LO unchanged; MULT still correct.
